fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the pipelined RISC-V core, immediately upstream of the branch unit. It owns the program counter (PC) and issues instruction-memory addresses. It latches the IF/ID pipeline register that supplies `Cur_PC` to the branch unit. It also consumes the branch unit's `PcSel`/`BrPC` redirect, handling load-use stalls, instruction-memory wait states and redirect flushes.

## Interface
Parameters:
- PC_W, 9: PC width in bits; byte address, word aligned.
- NOP, 32'h0000_0013: instruction (`addi x0,x0,0`) inserted into IF/ID on bubbles and flushes.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID.
- PcSel  input  1  redirect request from the branch unit.
- BrPC  input  32  redirect target from the branch unit.
- imem_ready  input  1  instruction memory returns valid data this cycle.
- imem_instr  input  32  instruction word at `imem_addr`; combinational read.
- imem_addr  output  PC_W  current PC; equals the PC register.
- if_id_pc  output  PC_W  PC of the instruction held in IF/ID.
- if_id_instr  output  32  instruction held in IF/ID.
- if_id_valid  output  1  IF/ID holds a real, non-squashed instruction.
- misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].
- fetch_count  output  32  number of valid instructions loaded into IF/ID; wraps modulo 2^32.

## Operation
- Registers: PC, IF/ID (pc, instr, valid), misalign_err, fetch_count.
- FSM states:
  - RUN: normal fetch.
  - WAIT: memory not ready.
  - REDIR: first cycle after a redirect.
- FSM transitions, evaluated each cycle in priority order (first match wins):
  1. reset: PC=0, IF/ID={0, NOP, 0}, misalign_err=0, fetch_count=0, state=RUN.
  2. PcSel=1: overrides stall and imem_ready.
     - PC <= BrPC[PC_W-1:0] with bits [1:0] forced to 00.
     - IF/ID <= {if_id_pc, NOP, 0}.
     - misalign_err <= misalign_err | (BrPC[1:0]!=0).
     - state <= REDIR.
     - BrPC bits above PC_W are ignored and do not set an error.
  3. stall=1: PC, IF/ID, fetch_count and state all hold.
  4. imem_ready=0: PC holds; IF/ID <= {PC, NOP, 0}; state <= WAIT.
  5. Otherwise (fetch): PC <= PC+4 modulo 2^PC_W; IF/ID <= {PC, imem_instr, 1}; fetch_count += 1; state <= RUN.
- REDIR and WAIT behave as RUN for next-cycle decisions. They exist only for observability and coverage.
- Arithmetic:
  - PC increment is PC_W-bit unsigned, so 2^PC_W-4 wraps to 0 without error.
  - fetch_count wraps from 32'hFFFF_FFFF to 0.
- Flushing younger instructions already in ID/EX is outside this block.

## Timing
- All outputs are registered except imem_addr, which is the PC register itself.
- Fetch latency:
  - Instruction at PC=A, accepted at edge N, appears in IF/ID after edge N.
  - imem_addr=A+4 after edge N.
- Redirect:
  - PcSel sampled high at edge N: imem_addr=target after N; IF/ID is a bubble after N.
  - The target instruction is valid in IF/ID after edge N+1, if no stall and imem_ready=1.
- Stall: outputs are bit-identical for every stalled cycle. A one-cycle stall adds exactly one cycle of fetch latency.
- Memory wait: one bubble per cycle imem_ready=0. Fetch resumes on the first ready cycle.
- Simultaneous events:
  - PcSel with stall: the redirect wins, because a stall must never lose a taken branch.
  - PcSel with imem_ready=0: the redirect wins, and the unreturned fetch is discarded.
- Reset asserted mid-operation: all state returns to reset values at the next edge, regardless of other inputs.

## Test plan
- Reset then 4 ready cycles with imem_instr=32'h0010_0093: imem_addr 0,4,8,12 then 16; if_id_pc 0,4,8,12; if_id_valid=1 from the first edge; fetch_count=4.
- Redirect with PcSel=1, BrPC=32'h40 at PC=8: next cycle imem_addr=0x40, if_id_instr=NOP, if_id_valid=0; one cycle later if_id_pc=0x40, valid=1; fetch_count unchanged during the bubble.
- stall=1 for 3 cycles at PC=0x10: imem_addr, if_id_* and fetch_count constant; on release PC advances to 0x14.
- PcSel=1 with stall=1, BrPC=0x80: redirect taken, imem_addr=0x80. Separately, BrPC=0x82: imem_addr=0x80 and misalign_err=1, staying 1 until reset.
- imem_ready=0 for 2 cycles at PC=0x20: two NOP bubbles with valid=0 and imem_addr held at 0x20; fetch_count increments only after ready returns. Wrap case: PC=0x1FC fetches, next PC=0x000.
- Reset asserted one cycle after a redirect: the next edge gives imem_addr=0, if_id_valid=0, misalign_err=0, fetch_count=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage and its surroundings: hazard/branch control in,
// instruction-memory port and IF/ID pipeline register out.
interface fetch_unit_if #(
  parameter int PC_W = 9
);
  logic            stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            imem_ready;
  logic [31:0]     imem_instr;
  logic [PC_W-1:0] imem_addr;
  logic [PC_W-1:0] if_id_pc;
  logic [31:0]     if_id_instr;
  logic            if_id_valid;
  logic            misalign_err;
  logic [31:0]     fetch_count;

  // Environment side: hazard unit, branch unit, instruction memory, decode.
  modport master (
    output stall, PcSel, BrPC, imem_ready, imem_instr,
    input  imem_addr, if_id_pc, if_id_instr, if_id_valid, misalign_err, fetch_count
  );

  // Fetch stage side.
  modport slave (
    input  stall, PcSel, BrPC, imem_ready, imem_instr,
    output imem_addr, if_id_pc, if_id_instr, if_id_valid, misalign_err, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// loads the IF/ID register, honouring redirects, load-use stalls and memory waits.
module fetch_unit #(
  parameter int          PC_W = 9,
  parameter logic [31:0] NOP  = 32'h0000_0013
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.slave bus
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_REDIR = 2'd2;

  logic [PC_W-1:0] pc_reg,        pc_next;
  logic [PC_W-1:0] ipc_reg,       ipc_next;
  logic [31:0]     instr_reg,     instr_next;
  logic            valid_reg,     valid_next;
  logic            misalign_reg,  misalign_next;
  logic [31:0]     count_reg,     count_next;
  logic [1:0]      state_reg,     state_next;

  logic [PC_W-1:0] redirect_target;
  logic            unused_brpc_hi;

  // Redirect targets are forced to word alignment; bits above the PC width are dropped.
  assign redirect_target = {bus.BrPC[PC_W-1:2], 2'b00};
  assign unused_brpc_hi  = ^bus.BrPC[31:PC_W];

  always_comb begin
    pc_next       = pc_reg;
    ipc_next      = ipc_reg;
    instr_next    = instr_reg;
    valid_next    = valid_reg;
    misalign_next = misalign_reg;
    count_next    = count_reg;
    state_next    = state_reg;

    if (bus.PcSel) begin
      // A taken branch beats both a stall and an outstanding memory fetch.
      pc_next       = redirect_target;
      instr_next    = NOP;
      valid_next    = 1'b0;
      misalign_next = misalign_reg | (bus.BrPC[1:0] != 2'b00);
      state_next    = ST_REDIR;
    end else if (bus.stall) begin
      pc_next = pc_reg;
    end else if (!bus.imem_ready) begin
      ipc_next   = pc_reg;
      instr_next = NOP;
      valid_next = 1'b0;
      state_next = ST_WAIT;
    end else begin
      pc_next    = pc_reg + PC_W'(4);
      ipc_next   = pc_reg;
      instr_next = bus.imem_instr;
      valid_next = 1'b1;
      count_next = count_reg + 32'd1;
      state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= '0;
      ipc_reg      <= '0;
      instr_reg    <= NOP;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      count_reg    <= '0;
      state_reg    <= ST_RUN;
    end else begin
      pc_reg       <= pc_next;
      ipc_reg      <= ipc_next;
      instr_reg    <= instr_next;
      valid_reg    <= valid_next;
      misalign_reg <= misalign_next;
      count_reg    <= count_next;
      state_reg    <= state_next;
    end
  end

  assign bus.imem_addr    = pc_reg;
  assign bus.if_id_pc     = ipc_reg;
  assign bus.if_id_instr  = instr_reg;
  assign bus.if_id_valid  = valid_reg;
  assign bus.misalign_err = misalign_reg;
  assign bus.fetch_count  = count_reg;

endmodule
